// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: button front end and run/pause/clear sequencer for a stopwatch.
//   - ps_in / rst_in are raw, asynchronous, bouncing buttons. Each one goes
//     through a 2-flop synchronizer and a debouncer that emits a one-cycle press.
//   - A three-state FSM (IDLE / RUN / PAUSE) turns presses into cnt_en, cnt_clr
//     and a divided tick_out for the downstream counter.
//   - Optional lap feature: define STOPWATCH_LAP_EN to let a clear press in RUN
//     toggle lap_hold (a display-freeze request). Without it lap_hold is tied 0.
module stopwatch_ctrl #(
  parameter int DEB_CYC  = 10,
  parameter int TICK_DIV = 10
) (
  input  logic       clk_in,
  input  logic       sys_rst_in,
  input  logic       ps_in,
  input  logic       rst_in,
  output logic       cnt_en,
  output logic       tick_out,
  output logic       cnt_clr,
  output logic [1:0] state_out,
  output logic       lap_hold
);

  localparam int DW = $clog2(DEB_CYC + 1);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [DW-1:0] DEB_MAX  = DW'(DEB_CYC);
  localparam logic [TW-1:0] DIV_LAST = TW'(TICK_DIV - 1);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_PAUSE = 2'b10;

  // Bit 0 is the pause/start button, bit 1 the clear button.
  logic [1:0] w_raw;
  logic [1:0] r_sync1;
  logic [1:0] r_sync2;
  logic [1:0] w_press;

  assign w_raw = {rst_in, ps_in};

  // Two-flop synchronizer for both raw buttons.
  // NOTE: clocked state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours; blocking here would collapse the chain.
  always_ff @(posedge clk_in or posedge sys_rst_in) begin
    if (sys_rst_in) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Per-button debouncer. A press needs DEB_CYC consecutive synchronized high
  // cycles while armed; re-arming needs DEB_CYC consecutive low cycles. Both
  // counters saturate at DEB_CYC. Buttons start disarmed so a button held
  // through reset cannot fire until it has been released.
  for (genvar g = 0; g < 2; g++) begin : g_btn
    logic [DW-1:0] r_hi_cnt;
    logic [DW-1:0] r_lo_cnt;
    logic [DW-1:0] w_lo_nxt;
    logic          r_armed;

    assign w_press[g] = r_armed & (r_hi_cnt == DEB_MAX);

    // Next value of the low-run counter, also used to arm in the same edge.
    // NOTE: every signal driven in always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
      w_lo_nxt = r_lo_cnt;
      if (r_sync2[g]) begin
        w_lo_nxt = '0;
      end else if (r_lo_cnt != DEB_MAX) begin
        w_lo_nxt = r_lo_cnt + DW'(1);
      end
    end

    // High/low run counters and the arm flag.
    always_ff @(posedge clk_in or posedge sys_rst_in) begin
      if (sys_rst_in) begin
        r_hi_cnt <= '0;
        r_lo_cnt <= '0;
        r_armed  <= 1'b0;
      end else begin
        if (!r_sync2[g]) begin
          r_hi_cnt <= '0;
        end else if (r_hi_cnt != DEB_MAX) begin
          r_hi_cnt <= r_hi_cnt + DW'(1);
        end
        r_lo_cnt <= w_lo_nxt;
        if (w_press[g]) begin
          r_armed <= 1'b0;
        end else if (w_lo_nxt == DEB_MAX) begin
          r_armed <= 1'b1;
        end
      end
    end
  end

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic          w_clr_nxt;
  logic          r_cnt_en;
  logic          r_cnt_clr;
  logic [TW-1:0] r_div;
  logic          r_tick;
`ifdef STOPWATCH_LAP_EN
  logic          w_lap_tgl;
`endif

  // Next-state decode. Clear beats start in IDLE/PAUSE; in RUN start (pause)
  // beats clear and a simultaneous clear press is dropped.
  always_comb begin
    w_state_nxt = r_state;
    w_clr_nxt   = 1'b0;
`ifdef STOPWATCH_LAP_EN
    w_lap_tgl   = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_press[1]) begin
          w_clr_nxt = 1'b1;
        end else if (w_press[0]) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_press[0]) begin
          w_state_nxt = ST_PAUSE;
`ifdef STOPWATCH_LAP_EN
        end else if (w_press[1]) begin
          w_lap_tgl = 1'b1;
`endif
        end
      end
      ST_PAUSE: begin
        if (w_press[1]) begin
          w_state_nxt = ST_IDLE;
          w_clr_nxt   = 1'b1;
        end else if (w_press[0]) begin
          w_state_nxt = ST_RUN;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register plus outputs registered from the next-state decode, so
  // cnt_en rises on the same edge state_out becomes RUN.
  always_ff @(posedge clk_in or posedge sys_rst_in) begin
    if (sys_rst_in) begin
      r_state   <= ST_IDLE;
      r_cnt_en  <= 1'b0;
      r_cnt_clr <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt_en  <= (w_state_nxt == ST_RUN);
      r_cnt_clr <= w_clr_nxt;
    end
  end

  // Tick divider: counts RUN cycles only, holds through PAUSE so a partial
  // interval survives, and clears whenever the FSM is (or enters) IDLE.
  // tick_out is registered, so it appears TICK_DIV cycles after RUN entry.
  always_ff @(posedge clk_in or posedge sys_rst_in) begin
    if (sys_rst_in) begin
      r_div  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      if (w_state_nxt == ST_IDLE) begin
        r_div <= '0;
      end else if (r_state == ST_RUN) begin
        if (r_div == DIV_LAST) begin
          r_div  <= '0;
          r_tick <= 1'b1;
        end else begin
          r_div <= r_div + TW'(1);
        end
      end
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic r_lap_hold;

  // Lap freeze: toggled by a clear press in RUN, dropped on (re)entering IDLE.
  always_ff @(posedge clk_in or posedge sys_rst_in) begin
    if (sys_rst_in) begin
      r_lap_hold <= 1'b0;
    end else if (w_state_nxt == ST_IDLE) begin
      r_lap_hold <= 1'b0;
    end else if (w_lap_tgl) begin
      r_lap_hold <= ~r_lap_hold;
    end
  end

  assign lap_hold = r_lap_hold;
`else
  assign lap_hold = 1'b0;
`endif

  assign state_out = r_state;
  assign cnt_en    = r_cnt_en;
  assign cnt_clr   = r_cnt_clr;
  assign tick_out  = r_tick;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: directed scenarios plus randomized
// button traffic, every cycle compared against a behavioural model built from
// run lengths of button levels and a count of RUN cycles.
module tb_stopwatch_ctrl;

  localparam int DEB_CYC  = 10;
  localparam int TICK_DIV = 10;
`ifdef STOPWATCH_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  logic       clk_in = 1'b0;
  logic       sys_rst_in = 1'b1;
  logic       ps_in = 1'b0;
  logic       rst_in = 1'b0;
  logic       cnt_en;
  logic       tick_out;
  logic       cnt_clr;
  logic [1:0] state_out;
  logic       lap_hold;

  stopwatch_ctrl #(.DEB_CYC(DEB_CYC), .TICK_DIV(TICK_DIV)) dut (
    .clk_in    (clk_in),
    .sys_rst_in(sys_rst_in),
    .ps_in     (ps_in),
    .rst_in    (rst_in),
    .cnt_en    (cnt_en),
    .tick_out  (tick_out),
    .cnt_clr   (cnt_clr),
    .state_out (state_out),
    .lap_hold  (lap_hold)
  );

  always #5 clk_in = ~clk_in;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  typedef enum int {M_IDLE, M_RUN, M_PAUSE} mode_t;

  mode_t m_st;
  int    m_run_cyc;
  bit    m_tick, m_clr, m_lap;
  bit    d1[2], d2[2];
  int    hi_run[2], lo_run[2];
  bit    armed[2], pend[2];

  function automatic logic [1:0] mode_code(input mode_t m);
    case (m)
      M_RUN:   return 2'b01;
      M_PAUSE: return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  function automatic void model_reset();
    m_st = M_IDLE; m_run_cyc = 0; m_tick = 0; m_clr = 0; m_lap = 0;
    for (int i = 0; i < 2; i++) begin
      d1[i] = 0; d2[i] = 0; hi_run[i] = 0; lo_run[i] = 0; armed[i] = 0; pend[i] = 0;
    end
  endfunction

  // One rising edge: the FSM reacts to presses decided on the previous edge,
  // then the button levels seen two edges ago extend the high/low runs.
  function automatic void model_edge(input bit p, input bit r);
    bit raw[2];
    bit s;
    bit pp = pend[0];
    bit pr = pend[1];
    m_clr  = 0;
    m_tick = 0;
    if (m_st == M_RUN) begin
      m_run_cyc++;
      m_tick = (m_run_cyc % TICK_DIV) == 0;
    end
    case (m_st)
      M_IDLE: begin
        m_lap = 0;
        if (pr) m_clr = 1;
        else if (pp) m_st = M_RUN;
      end
      M_RUN: begin
        if (pp) m_st = M_PAUSE;
        else if (pr && LAP_EN) m_lap = !m_lap;
      end
      default: begin
        if (pr) begin
          m_clr = 1; m_st = M_IDLE; m_run_cyc = 0; m_lap = 0;
        end else if (pp) m_st = M_RUN;
      end
    endcase
    raw[0] = p;
    raw[1] = r;
    for (int i = 0; i < 2; i++) begin
      s     = d2[i];
      d2[i] = d1[i];
      d1[i] = raw[i];
      if (s) begin hi_run[i]++; lo_run[i] = 0; end
      else   begin lo_run[i]++; hi_run[i] = 0; end
      if (lo_run[i] >= DEB_CYC) armed[i] = 1;
      pend[i] = armed[i] && (hi_run[i] == DEB_CYC);
      if (pend[i]) armed[i] = 0;
    end
  endfunction

  // ---------------- bookkeeping of observed events ----------------
  int         edge_n = 0;
  int         tick_cnt = 0, clr_cnt = 0, both_cnt = 0;
  int         last_tick_edge = 0, state_edge = -1;
  logic [1:0] prev_state = 2'b00;
  int         tick_q[$];

  // One clock cycle: drive at the falling edge, model the rising edge, and
  // compare all outputs 1 time unit later.
  task automatic cyc(input logic p, input logic r);
    ps_in  = p;
    rst_in = r;
    @(posedge clk_in);
    model_edge(p, r);
    #1;
    edge_n++;
    check("outputs", {26'd0, lap_hold, state_out, cnt_clr, tick_out, cnt_en},
          {26'd0, m_lap, mode_code(m_st), m_clr, m_tick, m_st == M_RUN});
    if (tick_out) begin
      tick_cnt++;
      last_tick_edge = edge_n;
      tick_q.push_back(edge_n);
    end
    if (cnt_clr) clr_cnt++;
    if (tick_out && cnt_clr) both_cnt++;
    if (state_out != prev_state) state_edge = edge_n;
    prev_state = state_out;
    @(negedge clk_in);
  endtask

  // Hold the given levels for 'hold' cycles, then release long enough to re-arm.
  task automatic push(input logic p, input logic r, input int hold);
    for (int i = 0; i < hold; i++) cyc(p, r);
    for (int i = 0; i < DEB_CYC + 3; i++) cyc(1'b0, 1'b0);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
  task automatic apply_reset(input logic hold_ps);
    ps_in  = hold_ps;
    rst_in = 1'b0;
    #2 sys_rst_in = 1'b1;
    #1 check("reset_outputs", {27'd0, lap_hold, state_out, cnt_clr, tick_out, cnt_en}, 32'd0);
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    sys_rst_in = 1'b0;
    model_reset();
    prev_state = 2'b00;
  endtask

  task automatic wait_ticks(input int n, input int budget);
    for (int i = 0; i < budget && tick_q.size() < n; i++) cyc(1'b0, 1'b0);
    check("tick_seen", tick_q.size() >= n, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int snap, p_edge, h, edge0;
    model_reset();
    @(negedge clk_in);
    apply_reset(1'b0);
    for (int i = 0; i < DEB_CYC + 3; i++) cyc(1'b0, 1'b0);

    // Short ps pulse: nothing happens.
    push(1'b1, 1'b0, DEB_CYC - 1);
    check("short_state", state_out, 2'b00);
    check("short_ticks", tick_cnt, 0);
    check("short_clr", clr_cnt, 0);

    // Full press: RUN at edge DEB_CYC+3, ticks every TICK_DIV cycles.
    tick_q.delete();
    state_edge = -1;
    edge0 = edge_n;
    push(1'b1, 1'b0, DEB_CYC);
    check("run_latency", state_edge - edge0, DEB_CYC + 3);
    check("run_cnt_en", cnt_en, 1'b1);
    wait_ticks(2, 40);
    if (tick_q.size() >= 2) begin
      check("first_tick", tick_q[0] - state_edge, TICK_DIV);
      check("tick_period", tick_q[1] - tick_q[0], TICK_DIV);
    end

    // Pause mid-interval, sit 100 cycles, resume: remainder of interval kept.
    for (int i = 0; i < $urandom_range(0, 9); i++) cyc(1'b0, 1'b0);
    push(1'b1, 1'b0, DEB_CYC);
    check("pause_state", state_out, 2'b10);
    p_edge = state_edge;
    h = (p_edge - last_tick_edge) % TICK_DIV;
    snap = tick_cnt;
    for (int i = 0; i < 100; i++) cyc(1'b0, 1'b0);
    check("pause_no_ticks", tick_cnt - snap, 0);
    tick_q.delete();
    push(1'b1, 1'b0, DEB_CYC);
    check("resume_state", state_out, 2'b01);
    wait_ticks(1, 20);
    if (tick_q.size() >= 1) check("resume_tick", tick_q[0] - state_edge, TICK_DIV - h);

    // Simultaneous presses in RUN: pause wins, no clear.
    snap = clr_cnt;
    push(1'b1, 1'b1, DEB_CYC);
    check("both_state", state_out, 2'b10);
    check("both_no_clr", clr_cnt - snap, 0);

    // Clear in PAUSE: short pulse ignored, full press clears once.
    push(1'b0, 1'b1, 7);
    check("clr_short_state", state_out, 2'b10);
    check("clr_short_cnt", clr_cnt - snap, 0);
    push(1'b0, 1'b1, DEB_CYC);
    check("clr_state", state_out, 2'b00);
    check("clr_once", clr_cnt - snap, 1);

    // Restart after clear: divider was zeroed.
    tick_q.delete();
    push(1'b1, 1'b0, DEB_CYC);
    wait_ticks(1, 30);
    if (tick_q.size() >= 1) check("restart_tick", tick_q[0] - state_edge, TICK_DIV);

`ifdef STOPWATCH_LAP_EN
    push(1'b0, 1'b1, DEB_CYC);
    check("lap_on", lap_hold, 1'b1);
    check("lap_cnt_en", cnt_en, 1'b1);
    push(1'b0, 1'b1, DEB_CYC);
    check("lap_off", lap_hold, 1'b0);
`endif

    // Async reset mid-RUN with ps held through it: no press until released.
    check("pre_reset_run", state_out, 2'b01);
    apply_reset(1'b1);
    for (int i = 0; i < 3 * DEB_CYC; i++) cyc(1'b1, 1'b0);
    check("held_no_press", state_out, 2'b00);
    for (int i = 0; i < DEB_CYC + 3; i++) cyc(1'b0, 1'b0);
    push(1'b1, 1'b0, DEB_CYC);
    check("after_release_run", state_out, 2'b01);

    // Random bouncy traffic on both buttons, checked cycle by cycle.
    for (int b = 0; b < 60; b++) begin
      int mode, len, gap;
      mode = $urandom_range(0, 3);
      len  = $urandom_range(1, 16);
      gap  = $urandom_range(1, 16);
      for (int i = 0; i < len; i++)
        cyc(mode[0] && ($urandom_range(0, 9) != 0), mode[1] && ($urandom_range(0, 9) != 0));
      for (int i = 0; i < gap; i++) cyc(1'b0, 1'b0);
    end

    check("tick_clr_exclusive", both_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
